// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece move controller.
package tetris_pkg;

  // Default playfield size.
  localparam int GRID_ROWS = 22;
  localparam int GRID_COLS = 10;

  // Pieces live in a 5x5 box; each extracted cell carries a 3-bit colour.
  localparam int PIECE_DIM   = 5;
  localparam int PIECE_CELLS = PIECE_DIM * PIECE_DIM;
  localparam int COLOR_W     = 3;

  // Number of cycles the extractor is enabled for one candidate.
  localparam int EXT_WINDOW = 25;

  typedef enum logic [1:0] {
    OP_LEFT   = 2'd0,
    OP_RIGHT  = 2'd1,
    OP_DOWN   = 2'd2,
    OP_ROTATE = 2'd3
  } move_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BOUNDS  = 3'd1,
    S_EXTRACT = 3'd2,
    S_COMPARE = 3'd3,
    S_RESP    = 3'd4
  } move_state_e;

  // Bit 5*i+j is cell (i,j).
  typedef logic [PIECE_CELLS-1:0] piece_mask_t;
  // Cell (i,j) occupies bits [15i+3j+2 : 15i+3j].
  typedef logic [PIECE_CELLS*COLOR_W-1:0] piece_frame_t;

endpackage

// File: rtl/frame_collide.sv
// Combinational collision test: any cell that the piece occupies and whose
// extracted colour is nonzero counts as a hit.
module frame_collide
  import tetris_pkg::*;
(
  input  logic [PIECE_CELLS-1:0]         mask,
  input  logic [PIECE_CELLS*COLOR_W-1:0] frame,
  output logic                           hit
);

  logic [PIECE_CELLS-1:0] cell_hit;

  // Cell index 5i+j maps to colour field 3*(5i+j), so a flat walk suffices.
  generate
    for (genvar gi = 0; gi < PIECE_CELLS; gi++) begin : g_cell
      assign cell_hit[gi] = mask[gi] & (|frame[gi*COLOR_W +: COLOR_W]);
    end
  endgenerate

  assign hit = |cell_hit;

endmodule

// File: rtl/move_ctrl.sv
// Move controller: accepts a move request, bounds-checks the candidate
// position, runs the frame extractor over the candidate, checks for a
// collision and returns a one-cycle response with the resulting anchor.
module move_ctrl
  import tetris_pkg::*;
#(
  parameter int GRID_ROWS    = tetris_pkg::GRID_ROWS,
  parameter int GRID_COLS    = tetris_pkg::GRID_COLS,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  output logic        req_ready,
  input  logic [4:0]  cur_row,
  input  logic [3:0]  cur_col,
  input  logic [24:0] piece_mask,
  input  logic [24:0] rot_mask,
  output logic        ext_en,
  output logic [4:0]  ext_row,
  output logic [3:0]  ext_col,
  input  logic        ext_done,
  input  logic [74:0] ext_frame,
  output logic        resp_valid,
  output logic        resp_ok,
  output logic        resp_landed,
  output logic        resp_err,
  output logic [4:0]  new_row,
  output logic [3:0]  new_col
);

  localparam int TO_W = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [4:0]      WIN_LAST = 5'(EXT_WINDOW);
  localparam int ROW_MAX = GRID_ROWS - PIECE_DIM;
  localparam int COL_MAX = GRID_COLS - PIECE_DIM;

  // State and datapath registers.
  move_state_e  state_reg,       state_next;
  move_op_e     op_reg,          op_next;
  logic [4:0]   row_reg,         row_next;
  logic [3:0]   col_reg,         col_next;
  piece_mask_t  mask_reg,        mask_next;
  piece_frame_t frame_reg,       frame_next;
  logic [4:0]   win_cnt_reg,     win_cnt_next;
  logic [TO_W-1:0] to_cnt_reg,   to_cnt_next;
  logic [4:0]   ext_row_reg,     ext_row_next;
  logic [3:0]   ext_col_reg,     ext_col_next;
  logic         resp_ok_reg,     resp_ok_next;
  logic         resp_landed_reg, resp_landed_next;
  logic         resp_err_reg,    resp_err_next;
  logic [4:0]   new_row_reg,     new_row_next;
  logic [3:0]   new_col_reg,     new_col_next;

  // Candidate position, one bit wider than the anchor so that a step off
  // either edge shows up as a large value instead of wrapping.
  logic [5:0] cand_row_w;
  logic [4:0] cand_col_w;
  logic       cand_oob;
  logic       win_open;
  logic       hit;

  // Candidate anchor derived from the latched request.
  always_comb begin
    cand_row_w = {1'b0, row_reg};
    cand_col_w = {1'b0, col_reg};
    unique case (op_reg)
      OP_LEFT:   cand_col_w = {1'b0, col_reg} - 5'd1;
      OP_RIGHT:  cand_col_w = {1'b0, col_reg} + 5'd1;
      OP_DOWN:   cand_row_w = {1'b0, row_reg} + 6'd1;
      default:   ;
    endcase
  end

  // Left from column 0 sets the extra MSB; everything else is a range check.
  assign cand_oob = ((op_reg == OP_LEFT) && cand_col_w[4])
                  || (int'(cand_col_w) > COL_MAX)
                  || (int'(cand_row_w) > ROW_MAX);

  assign win_open = (win_cnt_reg != WIN_LAST);

  frame_collide u_collide (
    .mask  (mask_reg),
    .frame (frame_reg),
    .hit   (hit)
  );

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    row_next         = row_reg;
    col_next         = col_reg;
    mask_next        = mask_reg;
    frame_next       = frame_reg;
    win_cnt_next     = win_cnt_reg;
    to_cnt_next      = to_cnt_reg;
    ext_row_next     = ext_row_reg;
    ext_col_next     = ext_col_reg;
    resp_ok_next     = resp_ok_reg;
    resp_landed_next = resp_landed_reg;
    resp_err_next    = resp_err_reg;
    new_row_next     = new_row_reg;
    new_col_next     = new_col_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_next    = move_op_e'(req_op);
          row_next   = cur_row;
          col_next   = cur_col;
          mask_next  = (move_op_e'(req_op) == OP_ROTATE) ? rot_mask : piece_mask;
          state_next = S_BOUNDS;
        end
      end

      S_BOUNDS: begin
        if (cand_oob) begin
          // Refused without touching the extractor; a blocked down move
          // means the piece has reached the floor.
          resp_ok_next     = 1'b0;
          resp_landed_next = (op_reg == OP_DOWN);
          resp_err_next    = 1'b0;
          new_row_next     = row_reg;
          new_col_next     = col_reg;
          state_next       = S_RESP;
        end else begin
          ext_row_next = cand_row_w[4:0];
          ext_col_next = cand_col_w[3:0];
          win_cnt_next = '0;
          to_cnt_next  = '0;
          state_next   = S_EXTRACT;
        end
      end

      S_EXTRACT: begin
        if (win_open) begin
          // Done is deliberately ignored here: a done left over from a
          // previous operation must not end this one early.
          win_cnt_next = win_cnt_reg + 5'd1;
        end else if (ext_done) begin
          frame_next = ext_frame;
          state_next = S_COMPARE;
        end else if (to_cnt_reg == TO_LAST) begin
          resp_ok_next     = 1'b0;
          resp_landed_next = 1'b0;
          resp_err_next    = 1'b1;
          new_row_next     = row_reg;
          new_col_next     = col_reg;
          state_next       = S_RESP;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      S_COMPARE: begin
        resp_ok_next     = ~hit;
        resp_landed_next = hit && (op_reg == OP_DOWN);
        resp_err_next    = 1'b0;
        new_row_next     = hit ? row_reg : cand_row_w[4:0];
        new_col_next     = hit ? col_reg : cand_col_w[3:0];
        state_next       = S_RESP;
      end

      S_RESP: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Register update with synchronous reset; reset aborts any operation
  // in flight without producing a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      op_reg          <= OP_LEFT;
      row_reg         <= '0;
      col_reg         <= '0;
      mask_reg        <= '0;
      frame_reg       <= '0;
      win_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
      ext_row_reg     <= '0;
      ext_col_reg     <= '0;
      resp_ok_reg     <= 1'b0;
      resp_landed_reg <= 1'b0;
      resp_err_reg    <= 1'b0;
      new_row_reg     <= '0;
      new_col_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      row_reg         <= row_next;
      col_reg         <= col_next;
      mask_reg        <= mask_next;
      frame_reg       <= frame_next;
      win_cnt_reg     <= win_cnt_next;
      to_cnt_reg      <= to_cnt_next;
      ext_row_reg     <= ext_row_next;
      ext_col_reg     <= ext_col_next;
      resp_ok_reg     <= resp_ok_next;
      resp_landed_reg <= resp_landed_next;
      resp_err_reg    <= resp_err_next;
      new_row_reg     <= new_row_next;
      new_col_reg     <= new_col_next;
    end
  end

  assign req_ready   = (state_reg == S_IDLE);
  assign resp_valid  = (state_reg == S_RESP);
  assign ext_en      = (state_reg == S_EXTRACT) && win_open;
  assign ext_row     = ext_row_reg;
  assign ext_col     = ext_col_reg;
  assign resp_ok     = resp_ok_reg;
  assign resp_landed = resp_landed_reg;
  assign resp_err    = resp_err_reg;
  assign new_row     = new_row_reg;
  assign new_col     = new_col_reg;

endmodule

// File: doc/move_ctrl.md
MOVE_CTRL -- requirements
Module: move_ctrl

Interface
REQ-001 SHALL have parameter GRID_ROWS, default 22, meaning playfield rows.
REQ-002 SHALL have parameter GRID_COLS, default 10, meaning playfield columns.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 16, meaning cycles allowed for ext_done after the extraction window closes.
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports:
- req_valid  in  1  move request.
- req_op  in  2  move code: 0 left, 1 right, 2 down, 3 rotate.
- req_ready  out  1  high only in IDLE.
- cur_row  in  5  active-piece anchor row.
- cur_col  in  4  active-piece anchor column.
- piece_mask  in  25  current 5x5 occupancy; bit 5*i+j is cell (i,j).
- rot_mask  in  25  rotated candidate occupancy.
- ext_en  out  1  extractor enable.
- ext_row  out  5  extractor row index.
- ext_col  out  4  extractor column index.
- ext_done  in  1  extractor done.
- ext_frame  in  75  extracted 5x5x3 colour frame; cell (i,j) is bits [15i+3j+2 : 15i+3j].
- resp_valid  out  1  one-cycle response pulse.
- resp_ok  out  1  move legal.
- resp_landed  out  1  a down move was refused by collision or the floor.
- resp_err  out  1  extractor timeout.
- new_row  out  5  resulting anchor row.
- new_col  out  4  resulting anchor column.

Function
REQ-006 SHALL implement the FSM IDLE -> BOUNDS -> EXTRACT -> COMPARE -> RESP -> IDLE; the BOUNDS-reject path SHALL go BOUNDS -> RESP.
REQ-007 SHALL accept a request only when req_valid && req_ready, and SHALL latch req_op, cur_row, cur_col and the applicable mask.
- Candidate: left col-1; right col+1; down row+1; rotate same anchor with rot_mask. All other ops use piece_mask.
REQ-008 In BOUNDS, the block SHALL reject without extraction any candidate with col-1 underflow, col > GRID_COLS-5, or row > GRID_ROWS-5.
- Rejection response: resp_ok=0, new_row/new_col = latched current position.
REQ-009 In EXTRACT, ext_row/ext_col SHALL hold the candidate and ext_en SHALL be high for exactly 25 consecutive cycles, counted by a 5-bit wait counter.
REQ-010 ext_done SHALL be ignored while ext_en is high, so that a stale done from a prior operation cannot be taken.
- After the window closes, the first cycle with ext_done=1 SHALL advance the FSM to COMPARE.
REQ-011 Collision SHALL be any cell where the candidate mask bit is 1 and the ext_frame cell is nonzero.
REQ-012 In COMPARE, the block SHALL register the response.
- Legal move: resp_ok=1, new position = candidate.
- Illegal move: resp_ok=0, position unchanged.
REQ-013 resp_landed SHALL be 1 only for op down with resp_ok=0, whether the refusal came from collision or the floor bound.
REQ-014 Timing, relative to acceptance edge T:
- BOUNDS in cycle T+1.
- ext_en high for cycles T+2..T+26.
- With ext_done at T+27, resp_valid SHALL be high in cycle T+29.
- For a bounds reject, resp_valid SHALL be high in cycle T+2.
REQ-015 If ext_done is not seen within DONE_TIMEOUT cycles after the window closes, the block SHALL respond with resp_err=1, resp_ok=0 and the position unchanged.
REQ-016 resp_valid SHALL be high for exactly one cycle; there is no back-pressure.
- resp_* and new_* SHALL hold their values until the next response.
REQ-017 req_valid SHALL be ignored while not in IDLE; a request arriving in the RESP cycle SHALL be accepted on the following cycle.
REQ-018 Arithmetic SHALL use widths one bit wider than the operands so that underflow and overflow are detectable; there SHALL be no wrap-around.

Reset
REQ-019 On rst, the block SHALL go to IDLE on the next edge and clear all counters.
- Output reset values: req_ready=1, ext_en=0, resp_valid=0, resp_ok=0, resp_landed=0, resp_err=0, ext_row=0, ext_col=0, new_row=0, new_col=0.
REQ-020 rst mid-operation SHALL abort the operation with no response pulse.
- The extractor SHALL share the same rst so that its counter restarts at 0.

Structure
REQ-021 The shared package tetris_pkg SHALL hold the move-op enum, the GRID_ROWS/GRID_COLS constants, the FSM state enum and the 5x5 frame/mask types.
REQ-022 A combinational sub-module frame_collide SHALL implement REQ-011: inputs 25-bit mask and 75-bit frame, output 1-bit hit.

Verification
REQ-023 Right from (0,0) on an empty grid -> resp_valid at T+29, resp_ok=1, new=(0,1), ext_en high for exactly 25 cycles.
REQ-024 Left from col 0 -> resp_valid at T+2, resp_ok=0, new_col=0, ext_en never asserted.
REQ-025 Down from row 17 -> rejected in BOUNDS with resp_landed=1 and row 17 held.
- Down from row 5 with an occupied frame cell under a mask bit -> resp_ok=0, resp_landed=1.
REQ-026 Rotate with rot_mask overlapping a nonzero cell while piece_mask does not overlap it -> resp_ok=0, resp_landed=0.
REQ-027 ext_done held at 0 -> resp_err=1 exactly DONE_TIMEOUT cycles after the window closes, then req_ready=1.
REQ-028 rst asserted at T+10 -> ext_en=0 and req_ready=1 from T+11, and no resp_valid pulse.
- A back-to-back request after reset -> normal T+29 response.
